cardinal_nic: RTL
=================

Name: cardinal_nic

Overview:
- Network interface controller for one node of the 4-node cardinal CMP; one instance per node inside cardinal_cmp.
- Responder to the processor's NIC register port (addr_nic, din_nic, dout_nic, nicEn, nicWrEn).
- Initiator/receiver toward the node's ring-router local port.
- Provides a 1-entry output channel buffer (processor to network) and a 1-entry input channel buffer (network to processor), each with a status flag.

Parameters:
- DATA_WIDTH, 64, packet/data width (bit 0 is MSB, big-endian [0:DATA_WIDTH-1]).
- VC_BIT, 0, index of the virtual-channel bit within an outgoing packet.

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESET  input  1  synchronous, active-high reset
- addr  input  2  processor register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
- d_in  input  DATA_WIDTH  processor write data
- d_out  output  DATA_WIDTH  processor read data (registered)
- nicEn  input  1  access enable; no effect when 0
- nicWrEn  input  1  1 = write, 0 = read (qualified by nicEn)
- net_si  input  1  router delivering a packet to NIC this cycle
- net_ri  output  1  NIC input buffer can accept (ready to router)
- net_di  input  DATA_WIDTH  packet from router
- net_so  output  1  NIC injecting a packet this cycle
- net_ro  input  1  router local input can accept
- net_do  output  DATA_WIDTH  packet to router
- net_polarity  input  1  router even/odd cycle indicator

Behaviour:
- Reset (RESET=1 at rising CLK): in_full=0, out_full=0, both buffers cleared to 0, d_out=0, net_so=0, net_do=0. net_ri=1 after reset. Reset overrides all simultaneous events and discards any buffered packets.
- net_ri = ~in_full, combinational from the register.
- Input capture: net_si=1 and in_full=0 at the edge: in_buf<=net_di, in_full<=1. net_si=1 while in_full=1: packet ignored, buffer unchanged.
- Processor read (nicEn=1, nicWrEn=0): d_out is updated at the edge and visible the next cycle (1-cycle latency, same as dmem).
  - addr 00: d_out<=in_buf; in_full<=0 if in_full was 1. Reading an empty buffer returns the stale contents and leaves in_full=0.
  - addr 01: d_out<={63'b0,in_full}.
  - addr 11: d_out<={63'b0,out_full}.
  - addr 10: d_out<=0.
  - Status values are taken from the pre-edge register value.
- d_out holds its last value when there is no read.
- Processor write (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0 (pre-edge): out_buf<=d_in, out_full<=1.
  - addr 10 with out_full=1: write dropped, including the cycle in which a send occurs.
  - Writes to 00, 01 or 11: no effect.
- Injection: net_so, net_do are registered.
  - Send condition at an edge: out_full=1, net_ro=1, and net_polarity != out_buf[VC_BIT].
  - When met: net_so<=1, net_do<=out_buf, out_full<=0.
  - Otherwise net_so<=0; net_do holds its value.
  - net_so is high for exactly one cycle per packet.
- Simultaneous events:
  - Router capture and processor read of addr 00 in the same edge cannot collide, because net_ri=0 while full.
  - A capture in the same edge as a status read returns the old status (0).
  - Send and write in the same edge: the write is dropped, the send completes.
- No back-to-back injection: the next packet needs a new processor write first.

Optional Feature:
- Macro NIC_ERR_STICKY_EN.
- Defined:
  - Sticky in_err is set when net_si=1 arrives while in_full=1.
  - Sticky out_err is set when an addr-10 write is dropped.
  - A status read returns {62'b0, err, full} for its channel and clears that channel's err in the same edge.
  - Both err bits reset to 0.
- Undefined: no err registers; status bit 62 reads 0; dropped events are silent.

Test Plan:
- Reset: hold RESET 5 cycles with random inputs -> d_out=0, net_so=0, net_ri=1; an out-status read after reset returns 0x0.
- Send path: write 0x8000_0000_0000_00AB to addr 10 with net_ro=1; polarity toggles starting at 0 -> out-status reads 1; net_so pulses one cycle when polarity=0 with net_do=0x8000_0000_0000_00AB; out-status then reads 0.
- Send blocked: out_full=1, net_ro=0 for 10 cycles -> net_so stays 0. Raise net_ro -> send at the first legal polarity. A second write while full is dropped and net_do keeps the first value.
- Receive path: net_si=1 with net_di=0x1234 -> net_ri falls next cycle; in-status reads 1; read addr 00 returns 0x1234 one cycle later; net_ri returns to 1.
- Overrun: second net_si=1 with 0x5678 while full -> buffer still 0x1234. With NIC_ERR_STICKY_EN, in-status reads 0x3, then 0x1 on the next read.
- Reset mid-operation: both buffers full, assert RESET for 1 cycle -> both statuses read 0, net_ri=1, no net_so pulse follows.

Source files
------------

// File: rtl/cardinal_nic.sv
// cardinal_nic: per-node NIC with a 1-entry output channel and a 1-entry input channel between the processor register port and the ring-router local port.
// Defining NIC_ERR_STICKY_EN adds sticky overrun/drop error bits to the status words.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [1:0]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    localparam logic [1:0] ADDR_IN_BUF     = 2'b00;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'b10;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'b11;

    logic [0:DATA_WIDTH-1] in_buf;
    logic [0:DATA_WIDTH-1] out_buf;
    logic                  in_full;
    logic                  out_full;

    logic                  rd_en;
    logic                  wr_en;
    logic                  capture;
    logic                  in_buf_rd;
    logic                  in_stat_rd;
    logic                  out_stat_rd;
    logic                  out_wr;
    logic                  send;
    logic [0:DATA_WIDTH-1] in_status;
    logic [0:DATA_WIDTH-1] out_status;
    logic [0:DATA_WIDTH-1] rd_data;

    assign rd_en       = nicEn & ~nicWrEn;
    assign wr_en       = nicEn & nicWrEn;
    assign in_buf_rd   = rd_en && (addr == ADDR_IN_BUF);
    assign in_stat_rd  = rd_en && (addr == ADDR_IN_STATUS);
    assign out_stat_rd = rd_en && (addr == ADDR_OUT_STATUS);

    assign net_ri  = ~in_full;
    assign capture = net_si & ~in_full;

    // A write can only land in an empty buffer and a send needs a full one, so a
    // write in the same edge as a send is dropped by construction.
    assign out_wr = wr_en && (addr == ADDR_OUT_BUF) && !out_full;
    assign send   = out_full && net_ro && (net_polarity != out_buf[VC_BIT]);

`ifdef NIC_ERR_STICKY_EN
    logic in_err;
    logic out_err;
    logic overrun;
    logic out_drop;

    assign overrun  = net_si & in_full;
    assign out_drop = wr_en && (addr == ADDR_OUT_BUF) && out_full;

    // A new error in the same edge as the clearing status read is kept.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_err  <= 1'b0;
            out_err <= 1'b0;
        end else begin
            if (overrun)
                in_err <= 1'b1;
            else if (in_stat_rd)
                in_err <= 1'b0;

            if (out_drop)
                out_err <= 1'b1;
            else if (out_stat_rd)
                out_err <= 1'b0;
        end
    end

    assign in_status  = {{(DATA_WIDTH-2){1'b0}}, in_err, in_full};
    assign out_status = {{(DATA_WIDTH-2){1'b0}}, out_err, out_full};
`else
    assign in_status  = {{(DATA_WIDTH-1){1'b0}}, in_full};
    assign out_status = {{(DATA_WIDTH-1){1'b0}}, out_full};
`endif

    // NOTE: give every always_comb output a default first so no path infers a latch.
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_IN_BUF:     rd_data = in_buf;
            ADDR_IN_STATUS:  rd_data = in_status;
            ADDR_OUT_STATUS: rd_data = out_status;
            default:         rd_data = '0;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET)
            d_out <= '0;
        else if (rd_en)
            d_out <= rd_data;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_buf  <= '0;
            in_full <= 1'b0;
        end else if (capture) begin
            in_buf  <= net_di;
            in_full <= 1'b1;
        end else if (in_buf_rd) begin
            in_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_buf  <= '0;
            out_full <= 1'b0;
            net_so   <= 1'b0;
            net_do   <= '0;
        end else begin
            net_so <= send;
            if (send) begin
                net_do   <= out_buf;
                out_full <= 1'b0;
            end else if (out_wr) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end
        end
    end

endmodule
